// File: rtl/dither_stream_ctrl_pkg.sv
// Shared types and constants for the dither stream controller: pixel width,
// filter modes, framing FSM states and the 4x4 Bayer threshold matrix.
package dither_stream_ctrl_pkg;

    localparam int PX_W = 4;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        GRAY   = 2'd1,
        DITHER = 2'd2,
        INVERT = 2'd3
    } mode_e;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_e;

    // Indexed [y mod 4][x mod 4]
    localparam logic [PX_W-1:0] BAYER [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

endpackage

// File: rtl/dither_px_op.sv
// Combinational per-pixel filter: bypass, gray (G copied to all channels),
// ordered dither on G against the Bayer threshold, or channel invert.
module dither_px_op
    import dither_stream_ctrl_pkg::*;
(
    input  mode_e           mode,
    input  logic [1:0]      x,
    input  logic [1:0]      y,
    input  logic [PX_W-1:0] in_r,
    input  logic [PX_W-1:0] in_g,
    input  logic [PX_W-1:0] in_b,
    output logic [PX_W-1:0] out_r,
    output logic [PX_W-1:0] out_g,
    output logic [PX_W-1:0] out_b
);

    logic [PX_W-1:0] thr;
    logic [PX_W-1:0] lvl;

    always_comb begin
        thr   = BAYER[y][x];
        lvl   = (in_g > thr) ? '1 : '0;
        out_r = in_r;
        out_g = in_g;
        out_b = in_b;
        case (mode)
            GRAY: begin
                out_r = in_g;
                out_g = in_g;
                out_b = in_g;
            end
            DITHER: begin
                out_r = lvl;
                out_g = lvl;
                out_b = lvl;
            end
            INVERT: begin
                out_r = ~in_r;
                out_g = ~in_g;
                out_b = ~in_b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dither_stream_ctrl.sv
// Framed RGB444 stream filter with one-cycle registered output, SOF framing FSM
// and SOF-synchronous mode switching. Resync counter enabled by DITHER_STREAM_RESYNC_CNT_EN.
module dither_stream_ctrl
    import dither_stream_ctrl_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_sof,
    input  logic [PX_W-1:0] s_r,
    input  logic [PX_W-1:0] s_g,
    input  logic [PX_W-1:0] s_b,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_sof,
    output logic [PX_W-1:0] m_r,
    output logic [PX_W-1:0] m_g,
    output logic [PX_W-1:0] m_b,
    input  logic [1:0]      mode_req,
    input  logic            mode_req_valid,
    output logic            mode_ack,
    output logic [1:0]      active_mode,
    output logic [9:0]      x_pixel,
    output logic [9:0]      y_pixel,
    output logic [7:0]      resync_cnt
);

    state_e          state_q, state_d;
    logic [9:0]      nx_q, nx_d, ny_q, ny_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            m_valid_q, m_valid_d, m_sof_q, m_sof_d;
    logic [PX_W-1:0] m_r_q, m_r_d, m_g_q, m_g_d, m_b_q, m_b_d;
    mode_e           mode_q, mode_d, pend_q, pend_d;
    logic            pend_v_q, pend_v_d, ack_q, ack_d;

    logic            accept, in_run, fwd, sof_fwd, last_beat;
    logic [9:0]      bx, by;
    mode_e           op_mode;
    logic [PX_W-1:0] op_r, op_g, op_b;

    assign s_ready   = !m_valid_q || m_ready;
    assign accept    = s_valid && s_ready;
    assign in_run    = (state_q == RUN);
    assign fwd       = accept && (s_sof || in_run);
    assign sof_fwd   = accept && s_sof;
    // An SOF beat always sits at (0,0), whatever the counters say
    assign bx        = s_sof ? '0 : nx_q;
    assign by        = s_sof ? '0 : ny_q;
    assign last_beat = fwd && (bx == 10'(IMG_W - 1)) && (by == 10'(IMG_H - 1));
    // The SOF beat itself already uses the pending mode
    assign op_mode   = (sof_fwd && pend_v_q) ? pend_q : mode_q;

    dither_px_op u_px_op (
        .mode  (op_mode),
        .x     (bx[1:0]),
        .y     (by[1:0]),
        .in_r  (s_r),
        .in_g  (s_g),
        .in_b  (s_b),
        .out_r (op_r),
        .out_g (op_g),
        .out_b (op_b)
    );

    always_comb begin
        state_d   = state_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        x_d       = x_q;
        y_d       = y_q;
        m_valid_d = m_valid_q;
        m_sof_d   = m_sof_q;
        m_r_d     = m_r_q;
        m_g_d     = m_g_q;
        m_b_d     = m_b_q;
        mode_d    = mode_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        ack_d     = 1'b0;

        if (m_ready) m_valid_d = 1'b0;

        if (fwd) begin
            m_valid_d = 1'b1;
            m_sof_d   = s_sof;
            m_r_d     = op_r;
            m_g_d     = op_g;
            m_b_d     = op_b;
            x_d       = bx;
            y_d       = by;
            state_d   = RUN;
            if (bx == 10'(IMG_W - 1)) begin
                nx_d = '0;
                ny_d = by + 10'd1;
            end else begin
                nx_d = bx + 10'd1;
                ny_d = by;
            end
            if (last_beat) begin
                state_d = WAIT_SOF;
                ny_d    = '0;
            end
        end

        if (sof_fwd) begin
            if (pend_v_q) begin
                mode_d = pend_q;
                ack_d  = 1'b1;
            end
            pend_v_d = 1'b0;
        end
        // A request arriving with the SOF beat waits for the following SOF
        if (mode_req_valid) begin
            pend_d   = mode_e'(mode_req);
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_SOF;
            nx_q      <= '0;
            ny_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_r_q     <= '0;
            m_g_q     <= '0;
            m_b_q     <= '0;
            mode_q    <= BYPASS;
            pend_q    <= BYPASS;
            pend_v_q  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            x_q       <= x_d;
            y_q       <= y_d;
            m_valid_q <= m_valid_d;
            m_sof_q   <= m_sof_d;
            m_r_q     <= m_r_d;
            m_g_q     <= m_g_d;
            m_b_q     <= m_b_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            ack_q     <= ack_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_sof       = m_sof_q;
    assign m_r         = m_r_q;
    assign m_g         = m_g_q;
    assign m_b         = m_b_q;
    assign mode_ack    = ack_q;
    assign active_mode = mode_q;
    assign x_pixel     = x_q;
    assign y_pixel     = y_q;

`ifdef DITHER_STREAM_RESYNC_CNT_EN
    // gap_q: a frame completed and no beat has been accepted since
    logic       gap_q, gap_d, resync_inc;
    logic [7:0] resync_q, resync_d;

    assign resync_inc = (sof_fwd && in_run) || (accept && !s_sof && !in_run && gap_q);

    always_comb begin
        gap_d    = gap_q;
        resync_d = resync_q;
        if (accept && !in_run) gap_d = 1'b0;
        if (last_beat)         gap_d = 1'b1;
        if (resync_inc && resync_q != 8'hFF) resync_d = resync_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_q    <= 1'b0;
            resync_q <= '0;
        end else begin
            gap_q    <= gap_d;
            resync_q <= resync_d;
        end
    end

    assign resync_cnt = resync_q;
`else
    assign resync_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dither_stream_ctrl.sv
// Scoreboard bench for dither_stream_ctrl: a frame-level reference model pushes
// expected output beats; an independent monitor checks whatever the DUT presents.
module tb_dither_stream_ctrl;

    localparam int W = 5;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0, s_ready, s_sof = 1'b0;
    logic [3:0] s_r = '0, s_g = '0, s_b = '0;
    logic       m_valid, m_ready = 1'b1, m_sof;
    logic [3:0] m_r, m_g, m_b;
    logic [1:0] mode_req = '0;
    logic       mode_req_valid = 1'b0, mode_ack;
    logic [1:0] active_mode;
    logic [9:0] x_pixel, y_pixel;
    logic [7:0] resync_cnt;

    always #5 clk = ~clk;

    dither_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
        .m_r(m_r), .m_g(m_g), .m_b(m_b),
        .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_ack(mode_ack),
        .active_mode(active_mode), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .resync_cnt(resync_cnt)
    );

    typedef struct {
        int r, g, b, sof, x, y, mode, ack, rs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   bt [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    // reference model: pix = index of next pixel in frame, -1 while waiting for SOF
    int   pix = -1, rs = 0, cur = 0, pend = 0;
    bit   gap = 0, pend_v = 0, force_stall = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void bump_rs();
`ifdef DITHER_STREAM_RESYNC_CNT_EN
        if (rs < 255) rs++;
`endif
    endfunction

    function automatic void model_beat(input int sof, input int r, input int g, input int b);
        exp_t e;
        int   idx = 0;
        bit   emit = 0;
        e.ack = 0;
        if (sof != 0) begin
            if (pix >= 0) bump_rs();
            e.ack = pend_v ? 1 : 0;
            if (pend_v) cur = pend;
            pend_v = 0;
            gap = 0;
            emit = 1;
        end else if (pix < 0) begin
            if (gap) bump_rs();
            gap = 0;
        end else begin
            idx = pix;
            emit = 1;
        end
        if (emit) begin
            e.x = idx % W;
            e.y = idx / W;
            e.sof = sof;
            e.mode = cur;
            case (cur)
                1: begin e.r = g; e.g = g; e.b = g; end
                2: begin
                    e.r = (g > bt[e.y % 4][e.x % 4]) ? 15 : 0;
                    e.g = e.r;
                    e.b = e.r;
                end
                3: begin e.r = 15 - r; e.g = 15 - g; e.b = 15 - b; end
                default: begin e.r = r; e.g = g; e.b = b; end
            endcase
            e.rs = rs;
            q.push_back(e);
            pix = idx + 1;
            if (pix == W * H) begin
                pix = -1;
                gap = 1;
            end
        end
    endfunction

    task automatic cyc(input bit v, input bit sof, input int r, input int g, input int b,
                       input bit rqv, input int rq, output bit acc);
        @(posedge clk);
        #2;
        s_valid = v; s_sof = sof; s_r = 4'(r); s_g = 4'(g); s_b = 4'(b);
        mode_req_valid = rqv; mode_req = 2'(rq);
        #1;
        chk("s_ready", int'(s_ready), int'(!m_valid || m_ready));
        acc = v && s_ready;
        if (acc) model_beat(int'(sof), r, g, b);
        if (rqv) begin
            pend = rq;
            pend_v = 1;
        end
    endtask

    task automatic send(input bit sof, input int r, input int g, input int b,
                        input bit rqv = 0, input int rq = 0);
        bit acc = 0;
        int n = 0;
        do begin
            cyc(1'b1, sof, r, g, b, rqv && n == 0, rq, acc);
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input bit rqv = 0, input int rq = 0);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, rqv && i == 0, rq, acc);
    endtask

    task automatic send_rnd(input bit sof);
        send(sof, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1; s_valid = 1'b0; mode_req_valid = 1'b0;
        pix = -1; gap = 0; rs = 0; cur = 0; pend_v = 0;
        q.delete();
        @(posedge clk);
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_sof", int'(m_sof), 0);
        chk("rst_m_rgb", int'({m_r, m_g, m_b}), 0);
        chk("rst_xy", int'({x_pixel, y_pixel}), 0);
        chk("rst_active_mode", int'(active_mode), 0);
        chk("rst_mode_ack", int'(mode_ack), 0);
        chk("rst_resync_cnt", int'(resync_cnt), 0);
        #1 reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_ready = force_stall ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Monitor: compare whatever is held on m_* against the head of the queue
    initial begin
        exp_t e;
        bit   shown = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                shown = 0;
            end else if (m_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got rgb=%h%h%h at (%0d,%0d) expected no beat",
                             m_r, m_g, m_b, x_pixel, y_pixel);
                end else begin
                    e = q[0];
                    chk("m_r", int'(m_r), e.r);
                    chk("m_g", int'(m_g), e.g);
                    chk("m_b", int'(m_b), e.b);
                    chk("m_sof", int'(m_sof), e.sof);
                    chk("x_pixel", int'(x_pixel), e.x);
                    chk("y_pixel", int'(y_pixel), e.y);
                    chk("active_mode", int'(active_mode), e.mode);
                    chk("resync_cnt", int'(resync_cnt), e.rs);
                    chk("mode_ack", int'(mode_ack), shown ? 0 : e.ack);
                    if (m_ready) begin
                        void'(q.pop_front());
                        shown = 0;
                    end else begin
                        shown = 1;
                    end
                end
            end else begin
                chk("mode_ack_idle", int'(mode_ack), 0);
                shown = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();

        // beats before any SOF are consumed silently
        repeat (3) send_rnd(1'b0);
        idle(2, 1'b1, 2);
        send(1'b1, 7, 5, 9);
        for (int i = 1; i < W * H; i++) send_rnd(1'b0);
        // frame gap: two non-SOF beats, counted once
        send_rnd(1'b0);
        send_rnd(1'b0);

        // dither with flat g=8 over a whole frame
        send(1'b1, 0, 8, 0);
        for (int i = 1; i < W * H; i++) send(1'b0, 0, 8, 0);

        // mid-frame invert request takes effect at the next SOF
        send(1'b1, 3, 1, 4);
        send_rnd(1'b0);
        idle(1, 1'b1, 3);
        for (int i = 2; i < W * H; i++) send_rnd(1'b0);
        send(1'b1, 1, 2, 3);

        // downstream stall while input stays valid
        force_stall = 1'b1;
        fork
            begin
                repeat (6) @(posedge clk);
                force_stall = 1'b0;
            end
        join_none
        repeat (4) send_rnd(1'b0);

        // early SOF at (2,1), with a gray request on the same beat
        send(1'b1, 1, 1, 1);
        for (int i = 1; i < W + 2; i++) send_rnd(1'b0);
        send(1'b1, 4, 6, 8, 1'b1, 1);
        for (int i = 1; i < W * H; i++) send_rnd(1'b0);
        send_rnd(1'b1);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            bit acc;
            cyc($urandom_range(3) != 0, $urandom_range(14) == 0,
                $urandom_range(15), $urandom_range(15), $urandom_range(15),
                $urandom_range(19) == 0, $urandom_range(3), acc);
        end

        // reset mid-frame: held beat discarded, restart needs SOF
        send_rnd(1'b1);
        repeat (3) send_rnd(1'b0);
        do_reset();
        repeat (2) send_rnd(1'b0);
        send_rnd(1'b1);
        repeat (3) send_rnd(1'b0);

        idle(1);
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", q.size(), 0);
        @(negedge clk);
        chk("resync_final", int'(resync_cnt), rs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
